apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB completer that terminates transfers from the team's APB master, backed by a word-addressed register file. It decodes setup and access phases, optionally inserts a fixed number of wait states, and flags `pslverr` on misaligned or out-of-range addresses. The block sits on the peripheral side of the APB bus and serves as the reference target for bridge and master bring-up.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: `paddr` width.
- `DATA_WIDTH`, default 32: `pwdata` and `prdata` width, and the register width.
- `NUM_REGS`, default 16: number of registers. Must be a power of two, ≥2.
- `WAIT_CYCLES`, default 2: wait states inserted per transfer. Range 0–15.

Ports:
- `pclk`  in  1: clock. All state changes on its rising edge.
- `preset_n`  in  1: asynchronous, active-low reset.
- `pselx`  in  1: slave select from the master.
- `penable`  in  1: access-phase strobe.
- `pwrite`  in  1: 1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH: byte address.
- `pwdata`  in  DATA_WIDTH: write data.
- `pready`  out  1: transfer completes in a cycle where `pready`=1.
- `pslverr`  out  1: error response. Valid only when `pready`=1, otherwise 0.
- `prdata`  out  DATA_WIDTH: read data. Valid only when `pready`=1 on a good read, otherwise 0.

## Operation
- Address decode:
  - Index = `paddr[2 +: log2(NUM_REGS)]`.
  - Error when `paddr[1:0]`≠0 or `paddr` ≥ NUM_REGS*4.
- States: IDLE, ACCESS.
- IDLE:
  - On `pselx`=1 and `penable`=0 (setup), latch addr, `pwrite`, `pwdata` and the error flag.
  - Load the wait counter with WAIT_CYCLES, then go to ACCESS.
  - `penable`=1 seen in IDLE without a preceding setup is ignored: no write, `pready`=0.
- ACCESS:
  - If `pselx`=0, abort to IDLE. No register update.
  - Otherwise, if the counter is ≠0, decrement it and hold `pready`=0.
  - When the counter is 0 and `penable`=1, drive `pready`=1 for one cycle, then go to IDLE.
- Completion cycle:
  - Good write: `reg[index]` ← latched `pwdata` at the closing edge.
  - Good read: `prdata` = `reg[index]`.
  - Error: `pslverr`=1, `prdata`=0, no register modified.
- Back-to-back transfers: a setup in the cycle after completion is accepted from IDLE, with no idle cycle required.
- Outputs `pready`, `pslverr` and `prdata` are combinational from state, counter and registers. Outside the completion cycle they are held at 0.

## Timing
- Reset values: all registers 0, state IDLE, counter 0, `pready`=0, `pslverr`=0, `prdata`=0.
- Reset asserted mid-transfer: immediate return to reset values. The in-flight write is lost.
- Cycle numbering: setup in cycle T0, first access cycle T1. `pready`=1 in cycle T1+WAIT_CYCLES.
  - Transfer length = 2+WAIT_CYCLES cycles.
  - Write data is visible to a read in the very next transfer.
- Addr/data changes during ACCESS are ignored. Values latched at setup are used.

## Configuration
- `APB_SLV_WAIT_EN` defined: wait-state counter compiled in, and WAIT_CYCLES is honoured.
- `APB_SLV_WAIT_EN` undefined:
  - Counter logic is absent and WAIT_CYCLES is ignored.
  - `pready`=1 in T1 for every transfer, giving zero wait states.

## Test plan
- Reset, then read addr 0x0 -> `prdata`=0x0, `pslverr`=0, `pready` high in T1+WAIT_CYCLES.
- Write 0xDEADBEEF to 0x8, then read 0x8 -> `prdata`=0xDEADBEEF. Registers 0x4 and 0xC unchanged at 0.
- Write to 0x40 (NUM_REGS=16) and to 0x6 -> `pslverr`=1 on completion. A subsequent read of all registers shows no change.
- Back-to-back: write 0x11 to 0x4, setup for read of 0x4 the cycle after completion -> read completes with `prdata`=0x11, no idle gap.
- Drop `pselx` in the second wait cycle of a write of 0x55 to 0x0 -> no `pready`, and reg0 stays 0. Then assert `preset_n`=0 mid-write of 0x77 to 0xC -> `pready`=0 immediately, reg3=0 after reset.
- With `APB_SLV_WAIT_EN` undefined and WAIT_CYCLES=2 -> `pready`=1 in T1 for both read and write.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer backed by a word-addressed register file.
// Setup phase latches address/direction/data/error; the access phase waits
// out an optional wait-state counter, then completes with pready for one cycle.
// Misaligned or out-of-range addresses complete with pslverr and no update.
// Optional feature macro: APB_SLV_WAIT_EN (wait-state counter honouring
// WAIT_CYCLES). Without it every transfer completes in its first access cycle.
//
// Handshake: a transfer is a setup cycle (pselx=1, penable=0) followed by
// access cycles (pselx=1, penable=1); it completes in the cycle where
// pready=1. Dropping pselx during access abandons the transfer with no side
// effects. pslverr and prdata are meaningful only while pready=1, else 0.
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Reject parameter values the decode and counter cannot represent.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_slave_regfile: WAIT_CYCLES must be 0..15");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
    $error("apb_slave_regfile: NUM_REGS must be a power of two >= 2");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic setup;
  logic addr_err;
  logic wait_done;
  logic done;

  assign setup    = pselx & ~penable;
  assign addr_err = (paddr[1:0] != 2'b00) || ((paddr >> (IDX_W + 2)) != '0);

`ifdef APB_SLV_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  assign wait_done = (cnt_q == 4'd0);

  // Wait-state counter register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) cnt_q <= 4'd0;
    else           cnt_q <= cnt_d;
  end
`else
  assign wait_done = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state, counter and completion decode.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
`ifdef APB_SLV_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup is not a transfer start.
        if (setup) begin
          state_d = ST_ACCESS;
`ifdef APB_SLV_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
`endif
        end
      end
      ST_ACCESS: begin
        if (!pselx) begin
          state_d = ST_IDLE;
        end else if (!wait_done) begin
`ifdef APB_SLV_WAIT_EN
          cnt_d = cnt_q - 4'd1;
`endif
        end else if (penable) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the transfer attributes during the setup cycle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && setup) begin
      idx_q   <= paddr[2 +: IDX_W];
      wr_q    <= pwrite;
      err_q   <= addr_err;
      wdata_q <= pwdata;
    end
  end

  // Register file: updated only at the closing edge of a good write.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (done && wr_q && !err_q) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

  // Response outputs, forced to zero outside the completion cycle.
  always_comb begin
    pready  = done;
    pslverr = done & err_q;
    prdata  = '0;
    if (done && !wr_q && !err_q) prdata = regs_q[idx_q];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a per-cycle compare against a
// transaction-level model, plus literal expectations from a queue.
module tb_apb_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int WC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int W = WC;
`else
  localparam int W = 0;
`endif

  logic          pclk;
  logic          preset_n;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic          pslverr;
  logic [DW-1:0] prdata;

  apb_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .WAIT_CYCLES(WC)
  ) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

  // ---------------- clock / reset ----------------
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0] model [NR];
  logic          exp_pready;
  logic          exp_pslverr;
  logic [DW-1:0] exp_prdata;
  bit            chk_en;
  logic [DW-1:0] exp_q[$];
  int            n_checks;
  int            n_fail;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the popped literal expectation.
  task automatic lit(input string name, input logic [DW-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h expected <empty queue>", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // Per-cycle compare of all response outputs.
  always @(negedge pclk) begin
    if (chk_en) begin
      check("pready", {31'b0, pready}, {31'b0, exp_pready});
      check("pslverr", {31'b0, pslverr}, {31'b0, exp_pslverr});
      check("prdata", prdata, exp_prdata);
    end
  end

  function automatic logic addr_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || (a >= AW'(NR * 4));
  endfunction

  task automatic exp_quiet();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      pselx = 1'b0; penable = 1'b0;
      exp_quiet();
    end
  endtask

  // Full transfer: setup, then W wait cycles, then the completion cycle.
  // Bus address/data are scrambled during access to prove setup latching.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          output logic [DW-1:0] rdata, output logic err);
    logic bad;
    int   idx;
    bad = addr_bad(addr);
    idx = int'(addr[5:2]);
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    exp_quiet();
    rdata = '0;
    err   = 1'b0;
    for (int i = 0; i <= W; i++) begin
      @(posedge pclk); #1;
      penable = 1'b1; paddr = ~addr; pwdata = ~data; pwrite = ~wr;
      exp_quiet();
      if (i == W) begin
        exp_pready  = 1'b1;
        exp_pslverr = bad;
        exp_prdata  = (!wr && !bad) ? model[idx] : '0;
      end
      @(negedge pclk);
      rdata = prdata;
      err   = pslverr;
    end
    if (wr && !bad) model[idx] = data;
  endtask

  // Write whose pselx drops before completion.
  task automatic apb_abort(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    exp_quiet();
    for (int i = 0; i < ((W >= 1) ? 1 : 0); i++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
      exp_quiet();
    end
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    exp_quiet();
  endtask

  // Write interrupted by reset during its first access cycle.
  task automatic apb_reset_mid(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    exp_quiet();
    @(posedge pclk); #1;
    penable = 1'b1;
    exp_quiet();
    #2;
    preset_n = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  logic [DW-1:0] rd;
  logic          er;

  initial begin
    n_checks = 0; n_fail = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    preset_n = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    exp_quiet();
    chk_en = 1'b1;
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;

    // Read after reset.
    apb_xfer(1'b0, 32'h0, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("rd0_after_reset", rd);

    // Write then read back; neighbours untouched.
    apb_xfer(1'b1, 32'h8, 32'hDEADBEEF, rd, er);
    apb_xfer(1'b0, 32'h8, 32'h0, rd, er);
    exp_q.push_back(32'hDEADBEEF); lit("rd_0x8", rd);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("rd_0x4", rd);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("rd_0xC", rd);

    // Error responses: out of range, misaligned write, misaligned read.
    idle(1);
    apb_xfer(1'b1, 32'h40, 32'hA5A5A5A5, rd, er);
    exp_q.push_back(32'h1); lit("err_0x40", {31'b0, er});
    apb_xfer(1'b1, 32'h6, 32'h5A5A5A5A, rd, er);
    exp_q.push_back(32'h1); lit("err_0x6", {31'b0, er});
    apb_xfer(1'b0, 32'h9, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("rd_misaligned_data", rd);
    apb_xfer(1'b0, 32'h7C, 32'h0, rd, er);
    exp_q.push_back(32'h1); lit("err_0x7C", {31'b0, er});

    // Sweep all registers: only reg2 holds data.
    for (int i = 0; i < NR; i++) begin
      apb_xfer(1'b0, AW'(i * 4), 32'h0, rd, er);
      exp_q.push_back((i == 2) ? 32'hDEADBEEF : 32'h0);
      lit("sweep", rd);
    end

    // Back-to-back write/read with no idle gap.
    idle(1);
    apb_xfer(1'b1, 32'h4, 32'h11, rd, er);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, er);
    exp_q.push_back(32'h11); lit("b2b_rd_0x4", rd);

    // penable without setup must not start a transfer.
    @(posedge pclk); #1;
    pselx = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h99;
    exp_quiet();
    idle(1);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("no_setup_no_write", rd);

    // Aborted write leaves reg0 alone.
    apb_abort(32'h0, 32'h55);
    idle(1);
    apb_xfer(1'b0, 32'h0, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("abort_reg0", rd);

    // Reset mid-write: the write is lost and all registers clear.
    apb_reset_mid(32'hC, 32'h77);
    idle(1);
    apb_xfer(1'b0, 32'hC, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("reset_reg3", rd);
    apb_xfer(1'b0, 32'h8, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("reset_reg2", rd);
    apb_xfer(1'b0, 32'h4, 32'h0, rd, er);
    exp_q.push_back(32'h0); lit("reset_reg1", rd);

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected end before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
